// File: rtl/grid_pkg.sv
// grid_pkg: shared types and defaults for the grid sprite mover.
// Direction encoding, FSM state type, map tile defaults and the
// priority picker used when several buttons rise in the same cycle.
package grid_pkg;

    localparam int TYPE_W_DEF    = 3;
    localparam int BLOCK_MIN_DEF = 3;

    typedef enum logic [2:0] {
        DIR_NONE = 3'd0,
        UP       = 3'd1,
        DOWN     = 3'd2,
        LEFT     = 3'd3,
        RIGHT    = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUERY  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // edges bit order: [3]=up [2]=down [1]=left [0]=right; up wins
    function automatic dir_t pick_dir(input logic [3:0] edges);
        if (edges[3]) return UP;
        if (edges[2]) return DOWN;
        if (edges[1]) return LEFT;
        if (edges[0]) return RIGHT;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/grid_edge_det.sv
// grid_edge_det: per-player button rising-edge detector and pending
// direction register. A fresh edge always wins over a grant clear, so
// a press landing in the grant cycle is kept as the next request.
module grid_edge_det
    import grid_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       clr,
    output logic [2:0] pend
);

    logic [3:0] btn_q;
    logic [3:0] edges;
    dir_t       pend_q;

    assign edges = btn & ~btn_q;
    assign pend  = pend_q;

    // level history and pending direction (newest edge overwrites)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q  <= 4'b0000;
            pend_q <= DIR_NONE;
        end else begin
            btn_q <= btn;
            if (|edges) begin
                pend_q <= pick_dir(edges);
            end else if (clr) begin
                pend_q <= DIR_NONE;
            end
        end
    end

endmodule

// File: rtl/grid_mover.sv
// grid_mover: moves NUM_PLAYERS sprites on a ROWS x COLS tile map.
// Button edges queue a direction per player; an arbiter serves them
// round-robin, asks the map about the target tile and commits the move
// when the tile is passable and no other sprite sits there.
// Optional macro GRID_WRAP_EN: off-grid targets wrap to the opposite
// edge instead of being dropped.
//
// state  | meaning
// IDLE   | pick next pending player, launch query for a legal target
// QUERY  | q_req held with a stable tile address until q_ack
// COMMIT | one cycle, moved pulse for an accepted move, back to IDLE
module grid_mover
    import grid_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int ROWS        = 30,
    parameter int COLS        = 40,
    parameter int COORD_W     = 10,
    parameter int TYPE_W      = TYPE_W_DEF,
    parameter int BLOCK_MIN   = BLOCK_MIN_DEF,
    parameter logic [NUM_PLAYERS*COORD_W-1:0] START_R = '0,
    parameter logic [NUM_PLAYERS*COORD_W-1:0] START_C = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PLAYERS-1:0]         btn_up,
    input  logic [NUM_PLAYERS-1:0]         btn_down,
    input  logic [NUM_PLAYERS-1:0]         btn_left,
    input  logic [NUM_PLAYERS-1:0]         btn_right,
    output logic                           q_req,
    output logic [COORD_W-1:0]             q_r,
    output logic [COORD_W-1:0]             q_c,
    input  logic                           q_ack,
    input  logic [TYPE_W-1:0]              q_type,
    output logic [NUM_PLAYERS*COORD_W-1:0] pos_r,
    output logic [NUM_PLAYERS*COORD_W-1:0] pos_c,
    output logic [NUM_PLAYERS-1:0]         moved,
    output logic                           busy
);

    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic signed [COORD_W:0] S_ROWS = (COORD_W+1)'(ROWS);
    localparam logic signed [COORD_W:0] S_COLS = (COORD_W+1)'(COLS);
    localparam logic signed [COORD_W:0] S_ONE  = (COORD_W+1)'(1);
    localparam logic [TYPE_W-1:0]       BLK    = TYPE_W'(BLOCK_MIN);

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              pend [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]  clr;
    logic                    grant_found;
    logic [PW-1:0]           grant_idx;
    logic [PW-1:0]           last_q;
    logic [PW-1:0]           gidx_q;
    logic                    grant_any;
    logic                    launch;
    logic                    accept;
    logic signed [COORD_W:0] cur_r, cur_c, dr, dc, tgt_r, tgt_c;
    logic                    off_grid;
    logic                    target_ok;
    logic [COORD_W-1:0]      fin_r, fin_c;
    logic [COORD_W-1:0]      tgt_r_q, tgt_c_q;
    logic [COORD_W-1:0]      pos_r_q [NUM_PLAYERS];
    logic [COORD_W-1:0]      pos_c_q [NUM_PLAYERS];
    logic                    occupied;
    logic                    move_ok;
    logic                    ok_q;

    assign grant_any = (state == IDLE) && grant_found;
    assign launch    = grant_any && target_ok;
    assign accept    = (state == QUERY) && q_ack;

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
        grid_edge_det u_edge (
            .clk  (clk),
            .rst  (rst),
            .btn  ({btn_up[i], btn_down[i], btn_left[i], btn_right[i]}),
            .clr  (clr[i]),
            .pend (pend[i])
        );
        assign clr[i] = grant_any && (grant_idx == PW'(i));
        assign pos_r[i*COORD_W +: COORD_W] = pos_r_q[i];
        assign pos_c[i*COORD_W +: COORD_W] = pos_c_q[i];
    end

    // round-robin search starting one past the last granted player
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_PLAYERS; k++) begin
            cand = (int'(last_q) + k) % NUM_PLAYERS;
            if (!grant_found && (pend[cand] != DIR_NONE)) begin
                grant_found = 1'b1;
                grant_idx   = cand[PW-1:0];
            end
        end
    end

    // target tile of the granted player, signed so row/col -1 is visible
    always_comb begin
        cur_r = {1'b0, pos_r_q[grant_idx]};
        cur_c = {1'b0, pos_c_q[grant_idx]};
        dr    = '0;
        dc    = '0;
        case (dir_t'(pend[grant_idx]))
            UP:      dr = -S_ONE;
            DOWN:    dr = S_ONE;
            LEFT:    dc = -S_ONE;
            RIGHT:   dc = S_ONE;
            default: ;
        endcase
        tgt_r    = cur_r + dr;
        tgt_c    = cur_c + dc;
        off_grid = tgt_r[COORD_W] || tgt_c[COORD_W] ||
                   (tgt_r >= S_ROWS) || (tgt_c >= S_COLS);
        fin_r    = tgt_r[COORD_W-1:0];
        fin_c    = tgt_c[COORD_W-1:0];
`ifdef GRID_WRAP_EN
        target_ok = 1'b1;
        if (off_grid) begin
            if (tgt_r[COORD_W]) begin
                fin_r = COORD_W'(ROWS - 1);
            end else if (tgt_r >= S_ROWS) begin
                fin_r = '0;
            end
            if (tgt_c[COORD_W]) begin
                fin_c = COORD_W'(COLS - 1);
            end else if (tgt_c >= S_COLS) begin
                fin_c = '0;
            end
        end
`else
        target_ok = ~off_grid;
`endif
    end

    // move decision on the ack cycle: passable tile and nobody else there
    always_comb begin
        occupied = 1'b0;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            if ((PW'(j) != gidx_q) && (pos_r_q[j] == tgt_r_q) &&
                (pos_c_q[j] == tgt_c_q)) begin
                occupied = 1'b1;
            end
        end
        move_ok = (q_type < BLK) && !occupied;
    end

    // arbiter pointer, query address, positions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q  <= '0;
            gidx_q  <= '0;
            tgt_r_q <= '0;
            tgt_c_q <= '0;
            ok_q    <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                pos_r_q[i] <= START_R[i*COORD_W +: COORD_W];
                pos_c_q[i] <= START_C[i*COORD_W +: COORD_W];
            end
        end else begin
            if (grant_any) begin
                last_q <= grant_idx;
            end
            if (launch) begin
                gidx_q  <= grant_idx;
                tgt_r_q <= fin_r;
                tgt_c_q <= fin_c;
            end
            if (accept) begin
                ok_q <= move_ok;
                if (move_ok) begin
                    pos_r_q[gidx_q] <= tgt_r_q;
                    pos_c_q[gidx_q] <= tgt_c_q;
                end
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = QUERY;
            QUERY:   if (q_ack) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state-decoded outputs; moved is already reflected in the positions
    always_comb begin
        q_req = (state == QUERY);
        busy  = (state != IDLE);
        moved = '0;
        if ((state == COMMIT) && ok_q) begin
            moved[gidx_q] = 1'b1;
        end
    end

    assign q_r = tgt_r_q;
    assign q_c = tgt_c_q;

endmodule

// File: tb/tb_grid_mover.sv
// tb_grid_mover: directed scenarios plus a randomized run for grid_mover,
// checked every cycle against a behavioural model of players, pending
// requests, the round-robin arbiter and the tile map.
module tb_grid_mover;

    localparam int NP    = 2;
    localparam int ROWS  = 30;
    localparam int COLS  = 40;
    localparam int CW    = 10;
    localparam int TW    = 3;
    localparam int BLOCK = 3;
    localparam logic [NP*CW-1:0] SR = {10'd5, 10'd5};
    localparam logic [NP*CW-1:0] SC = {10'd6, 10'd5};
    localparam int D_UP = 1, D_DOWN = 2, D_LEFT = 3, D_RIGHT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NP-1:0]     btn_up = '0, btn_down = '0, btn_left = '0, btn_right = '0;
    logic              q_req;
    logic [CW-1:0]     q_r, q_c;
    logic              q_ack = 1'b0;
    logic [TW-1:0]     q_type = '0;
    logic [NP*CW-1:0]  pos_r, pos_c;
    logic [NP-1:0]     moved;
    logic              busy;

    always #5 clk = ~clk;

    grid_mover #(
        .NUM_PLAYERS (NP),
        .ROWS        (ROWS),
        .COLS        (COLS),
        .COORD_W     (CW),
        .TYPE_W      (TW),
        .BLOCK_MIN   (BLOCK),
        .START_R     (SR),
        .START_C     (SC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .q_req     (q_req),
        .q_r       (q_r),
        .q_c       (q_c),
        .q_ack     (q_ack),
        .q_type    (q_type),
        .pos_r     (pos_r),
        .pos_c     (pos_c),
        .moved     (moved),
        .busy      (busy)
    );

    int tiles [ROWS][COLS];
    int ack_delay = 0;
    int qwait = 0;
    bit spur_en = 1'b0;
    int errors = 0;
    int checks = 0;

    // reference model (0 idle, 1 waiting for map, 2 committing)
    int m_state = 0, m_last = 0, m_tr = 0, m_tc = 0, m_g = 0, m_ok = 0;
    int m_pend [NP];
    bit m_prev [NP][4];
    int m_r [NP];
    int m_c [NP];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pr(input int p);
        return int'(pos_r[p*CW +: CW]);
    endfunction

    function automatic int pc(input int p);
        return int'(pos_c[p*CW +: CW]);
    endfunction

    task automatic m_reset();
        logic [NP*CW-1:0] sr, sc;
        sr = SR;
        sc = SC;
        m_state = 0; m_last = 0; m_tr = 0; m_tc = 0; m_g = 0; m_ok = 0;
        for (int p = 0; p < NP; p++) begin
            m_pend[p] = 0;
            for (int k = 0; k < 4; k++) m_prev[p][k] = 1'b0;
            m_r[p] = int'(sr[p*CW +: CW]);
            m_c[p] = int'(sc[p*CW +: CW]);
        end
    endtask

    task automatic m_step();
        int ed [NP];
        bit b [4];
        int grant, nstate, cand, tr, tc, dr, dc;
        bit off, ok;
        grant  = -1;
        nstate = m_state;
        for (int p = 0; p < NP; p++) begin
            b[0] = btn_up[p]; b[1] = btn_down[p]; b[2] = btn_left[p]; b[3] = btn_right[p];
            ed[p] = 0;
            for (int k = 3; k >= 0; k--) if (b[k] && !m_prev[p][k]) ed[p] = k + 1;
            for (int k = 0; k < 4; k++) m_prev[p][k] = b[k];
        end
        if (m_state == 0) begin
            for (int k = 1; k <= NP; k++) begin
                cand = (m_last + k) % NP;
                if (grant < 0 && m_pend[cand] != 0) grant = cand;
            end
            if (grant >= 0) begin
                dr = 0; dc = 0;
                case (m_pend[grant])
                    D_UP:    dr = -1;
                    D_DOWN:  dr = 1;
                    D_LEFT:  dc = -1;
                    D_RIGHT: dc = 1;
                    default: ;
                endcase
                tr  = m_r[grant] + dr;
                tc  = m_c[grant] + dc;
                off = (tr < 0) || (tr >= ROWS) || (tc < 0) || (tc >= COLS);
`ifdef GRID_WRAP_EN
                tr  = (tr + ROWS) % ROWS;
                tc  = (tc + COLS) % COLS;
                off = 1'b0;
`endif
                m_last = grant;
                if (!off) begin
                    m_tr = tr; m_tc = tc; m_g = grant; nstate = 1;
                end
            end
        end else if (m_state == 1) begin
            if (q_ack) begin
                ok = (int'(q_type) < BLOCK);
                for (int p = 0; p < NP; p++)
                    if (p != m_g && m_r[p] == m_tr && m_c[p] == m_tc) ok = 1'b0;
                m_ok = int'(ok);
                if (ok) begin
                    m_r[m_g] = m_tr;
                    m_c[m_g] = m_tc;
                end
                nstate = 2;
            end
        end else begin
            nstate = 0;
        end
        for (int p = 0; p < NP; p++) begin
            if (ed[p] != 0) m_pend[p] = ed[p];
            else if (p == grant) m_pend[p] = 0;
        end
        m_state = nstate;
    endtask

    // compare DUT against model mid-cycle, then advance the model
    always @(negedge clk) begin
        logic [NP-1:0] em;
        if (!rst) begin
            m_reset();
            check("rst_q_req", int'(q_req), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_moved", int'(moved), 0);
            check("rst_q_r", int'(q_r), 0);
            check("rst_q_c", int'(q_c), 0);
            for (int p = 0; p < NP; p++) begin
                check("rst_pos_r", pr(p), m_r[p]);
                check("rst_pos_c", pc(p), m_c[p]);
            end
        end else begin
            em = '0;
            if (m_state == 2 && m_ok != 0) em[m_g] = 1'b1;
            check("q_req", int'(q_req), int'(m_state == 1));
            check("busy", int'(busy), int'(m_state != 0));
            check("moved", int'(moved), int'(em));
            if (m_state == 1) begin
                check("q_r", int'(q_r), m_tr);
                check("q_c", int'(q_c), m_tc);
            end
            for (int p = 0; p < NP; p++) begin
                check("pos_r", pr(p), m_r[p]);
                check("pos_c", pc(p), m_c[p]);
            end
            m_step();
        end
    end

    // one clock, then play the map responder for the new cycle
    task automatic tick();
        @(posedge clk);
        #1;
        if (q_req) begin
            if (qwait >= ack_delay) begin
                q_ack = 1'b1;
                if (int'(q_r) < ROWS && int'(q_c) < COLS)
                    q_type = TW'(tiles[int'(q_r)][int'(q_c)]);
                else
                    q_type = '0;
                qwait = 0;
            end else begin
                q_ack  = 1'b0;
                q_type = TW'($urandom);
                qwait++;
            end
        end else begin
            qwait  = 0;
            q_ack  = spur_en && ($urandom_range(0, 3) == 0);
            q_type = TW'($urandom);
        end
    endtask

    task automatic set_btn(input int p, input int d, input bit v);
        case (d)
            D_UP:    btn_up[p]    = v;
            D_DOWN:  btn_down[p]  = v;
            D_LEFT:  btn_left[p]  = v;
            default: btn_right[p] = v;
        endcase
    endtask

    task automatic press(input int p, input int d);
        set_btn(p, d, 1'b1);
        tick();
        set_btn(p, d, 1'b0);
    endtask

    task automatic press_wait(input int p, input int d);
        press(p, d);
        repeat (12) tick();
    endtask

    task automatic window(input int n, output int sq, output int sm);
        sq = 0;
        sm = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (q_req) sq = 1;
            if (moved != '0) sm = 1;
        end
    endtask

    initial begin
        int sq, sm, first, second;
        logic [NP-1:0] bv;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) tiles[r][c] = 0;
        m_reset();
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // P0 (5,5) right into P1 at (5,6): queried but rejected
        press(0, D_RIGHT);
        window(8, sq, sm);
        check("occ_query_seen", sq, 1);
        check("occ_no_move", sm, 0);
        check("occ_pos_c0", pc(0), 5);

        // clear the way, then latency of an accepted move
        press_wait(1, D_DOWN);
        press(0, D_RIGHT);
        check("lat_n1_q_req", int'(q_req), 0);
        tick();
        check("lat_n2_q_req", int'(q_req), 1);
        check("lat_n2_q_r", int'(q_r), 5);
        check("lat_n2_q_c", int'(q_c), 6);
        tick();
        check("lat_n3_moved", int'(moved), 1);
        check("lat_n3_pos_c0", pc(0), 6);
        check("lat_n3_pos_r0", pr(0), 5);
        repeat (4) tick();

        // blocking tile above (5,5)
        press_wait(0, D_LEFT);
        tiles[4][5] = 3;
        press(0, D_UP);
        window(8, sq, sm);
        check("blk_query_seen", sq, 1);
        check("blk_no_move", sm, 0);
        check("blk_pos_r0", pr(0), 5);
        check("blk_pos_c0", pc(0), 5);
        tiles[4][5] = 0;

        // walk to the corner, then push off the top edge
        repeat (5) press_wait(0, D_UP);
        repeat (5) press_wait(0, D_LEFT);
        check("corner_r0", pr(0), 0);
        check("corner_c0", pc(0), 0);
        press(0, D_UP);
        window(8, sq, sm);
`ifdef GRID_WRAP_EN
        check("edge_wrap_query", sq, 1);
        check("edge_wrap_r0", pr(0), ROWS - 1);
        press_wait(0, D_DOWN);
`else
        check("edge_no_query", sq, 0);
        check("edge_no_move", sm, 0);
        check("edge_r0", pr(0), 0);
`endif

        // simultaneous requests after a P0 grant: P1 first, slow map
        ack_delay = 5;
        btn_right[0] = 1'b1;
        btn_right[1] = 1'b1;
        tick();
        btn_right = '0;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("rr_hold_req", int'(q_req), 1);
            check("rr_hold_r", int'(q_r), 6);
            check("rr_hold_c", int'(q_c), 7);
            tick();
        end
        first = 0;
        second = 0;
        for (int i = 0; i < 30; i++) begin
            bv = moved;
            if (bv != '0) begin
                if (first == 0) first = int'(bv);
                else if (second == 0) second = int'(bv);
            end
            tick();
        end
        check("rr_first", first, 2);
        check("rr_second", second, 1);

        // reset in the middle of a query, late ack afterwards
        ack_delay = 20;
        press(0, D_DOWN);
        tick();
        check("rq_query", int'(q_req), 1);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        q_ack  = 1'b1;
        q_type = '0;
        window(6, sq, sm);
        check("rq_no_query", sq, 0);
        check("rq_no_move", sm, 0);
        check("rq_busy", int'(busy), 0);
        check("rq_p0_r", pr(0), 5);
        check("rq_p0_c", pc(0), 5);
        check("rq_p1_r", pr(1), 5);
        check("rq_p1_c", pc(1), 6);

        // randomized traffic against the model
        spur_en = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) tiles[r][c] = int'($urandom_range(0, 5));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ack_delay = int'($urandom_range(0, 3));
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 7) == 0) btn_up[p]    = ~btn_up[p];
                if ($urandom_range(0, 7) == 0) btn_down[p]  = ~btn_down[p];
                if ($urandom_range(0, 7) == 0) btn_left[p]  = ~btn_left[p];
                if ($urandom_range(0, 7) == 0) btn_right[p] = ~btn_right[p];
            end
            tick();
        end
        btn_up = '0; btn_down = '0; btn_left = '0; btn_right = '0;
        spur_en = 1'b0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grid_mover.md
GRID_MOVER -- requirements
Module: grid_mover

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of independently controlled grid sprites (1..4).
REQ-002 Parameter ROWS, default 30, grid rows; COLS, default 40, grid columns.
REQ-003 Parameter COORD_W, default 10, coordinate width; TYPE_W, default 3, map tile-type width.
REQ-004 Parameter BLOCK_MIN, default 3, lowest tile type that blocks movement.
REQ-005 Parameters START_R / START_C, packed NUM_PLAYERS*COORD_W, reset positions.
REQ-006 clk  in  1  single system clock (all logic on rising edge).
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 btn_up, btn_down, btn_left, btn_right  in  NUM_PLAYERS each  debounced button levels, bit i = player i.
REQ-009 q_req  out  1  map query request; q_r, q_c  out  COORD_W  queried tile.
REQ-010 q_ack  in  1  query answered this cycle; q_type  in  TYPE_W  tile type, valid with q_ack.
REQ-011 pos_r, pos_c  out  NUM_PLAYERS*COORD_W  current player positions, packed.
REQ-012 moved  out  NUM_PLAYERS  one-cycle pulse when player i commits a move; busy  out  1  FSM not IDLE.

Function
REQ-013 Per player, per button: rising-edge detect against a registered copy of the level.
REQ-014 Edge registers a pending direction per player; simultaneous edges: priority up > down > left > right; newer edge overwrites older pending.
REQ-015 FSM states IDLE, QUERY, COMMIT.
REQ-016 IDLE: round-robin grant among players with pending set, starting after last granted; grant clears that player's pending and computes target.
REQ-017 Edge on granted player in grant cycle is kept as new pending (not cleared).
REQ-018 Target off-grid (row<0, row>=ROWS, col<0, col>=COLS): rejected in IDLE, no query, no moved pulse, stay IDLE.
REQ-019 Valid target: next cycle QUERY; q_req=1 with q_r/q_c stable until q_ack sampled high; q_type captured on that cycle; q_ack allowed first QUERY cycle.
REQ-020 COMMIT (one cycle): move if q_type < BLOCK_MIN and no other player currently occupies target; then pos updated and moved[i]=1 in that cycle; return to IDLE.
REQ-021 Minimum latency: edge at cycle n -> pending n+1 -> grant/IDLE n+1 -> q_req n+2 -> COMMIT/moved n+3 (ack immediate).
REQ-022 q_ack outside QUERY ignored; q_req never asserted outside QUERY.
REQ-023 Arithmetic on COORD_W+1 signed width for bound checks; positions always within grid.

Reset
REQ-024 rst low: FSM IDLE, q_req=0, q_r=q_c=0, moved=0, busy=0, pending cleared, edge registers cleared, pos = START_R/START_C, round-robin pointer = player 0.
REQ-025 Reset mid-QUERY abandons the query; any later q_ack ignored.

Configuration
REQ-026 Macro GRID_WRAP_EN defined: off-grid target wraps (row -1 -> ROWS-1, ROWS -> 0, same for cols) and is queried normally.
REQ-027 GRID_WRAP_EN undefined: off-grid behaviour per REQ-018.

Structure
REQ-028 Shared package grid_pkg holds direction enum (DIR_NONE, UP, DOWN, LEFT, RIGHT), FSM state type, TYPE_W default and BLOCK_MIN default.
REQ-029 One sub-module grid_edge_det: per-player 4-bit edge detect + priority pending register, instantiated NUM_PLAYERS times.

Verification
REQ-030 P0 at (5,5), btn_right edge, q_ack immediate with q_type=0 -> q_r=5,q_c=6 at n+2; pos_c[0]=6 and moved=01 at n+3.
REQ-031 P0 at (5,5), btn_up, q_type=3 -> query issued, no move, moved stays 0, pos unchanged.
REQ-032 P0 at (0,0), btn_up, wrap off -> no q_req, pos (0,0); wrap on -> q_r=ROWS-1=29, move to (29,0).
REQ-033 P0 and P1 edges same cycle, last grant P0 -> P1 serviced first, P0 second; q_ack delayed 5 cycles holds q_r/q_c stable.
REQ-034 P1 at (5,6), P0 at (5,5) btn_right, q_type=0 -> rejected by occupancy, no moved pulse.
REQ-035 rst low during QUERY then q_ack pulse after release -> positions = START values, FSM IDLE, no moved pulse.
